// File: rtl/memory_system_pkg.sv
// rtl/memory_system_pkg.sv - shared widths, FSM states and cache line layout
package memory_system_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int NUM_SETS  = 4;
  localparam int INDEX_W   = 2;
  localparam int TAG_W     = ADDR_W - INDEX_W - 2;
  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_line_t;

endpackage

// File: rtl/memory_system_main_memory.sv
// rtl/memory_system_main_memory.sv - fixed-latency word memory, one op at a time
// o_ready pulses in the LATENCY-th cycle that i_req is held; writes commit on that edge.
module main_memory
  import memory_system_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wen,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ready
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH] = '{default: '0};
  logic [CNT_W-1:0]  r_cnt;
  logic              r_turn;

  assign o_ready = i_req && !r_turn && (r_cnt == CNT_W'(LATENCY - 1));
  assign o_rdata = r_mem[i_addr];

  // A completed write leaves one idle bus cycle before the next op starts counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_turn <= 1'b0;
    end else if (r_turn) begin
      r_turn <= 1'b0;
    end else if (o_ready) begin
      r_cnt  <= '0;
      r_turn <= i_wen;
    end else if (i_req) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (o_ready && i_wen) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/memory_system.sv
// rtl/memory_system.sv - 2-way set-associative write-back cache in front of main_memory
module memory_system
  import memory_system_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid_CPU,
  input  logic [ADDR_W-1:0] reqAddress_CPU,
  input  logic [DATA_W-1:0] reqDataIn_CPU,
  input  logic              reqWen_CPU,
  output logic [DATA_W-1:0] respDataOut_CPU,
  output logic              respHit_CPU
);

  state_t            r_state;
  logic [ADDR_W-1:2] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  cache_line_t       r_lines [NUM_SETS][2];
  logic [NUM_SETS-1:0] r_lru;
  logic              r_victim;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_hit;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  cache_line_t        w_line0;
  cache_line_t        w_line1;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_hit_way;
  logic [DATA_W-1:0]  w_hit_data;
  logic               w_miss_victim;
  cache_line_t        w_miss_line;
  logic [TAG_W-1:0]   w_victim_tag;
  logic [DATA_W-1:0]  w_victim_data;
  logic               w_mem_req;
  logic               w_mem_wen;
  logic [MEM_AW-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_rdata;
  logic               w_mem_ready;
  logic               w_unused;

  assign w_tag      = r_addr[ADDR_W-1:INDEX_W+2];
  assign w_index    = r_addr[INDEX_W+1:2];
  assign w_line0    = r_lines[w_index][0];
  assign w_line1    = r_lines[w_index][1];
  assign w_hit0     = w_line0.valid && (w_line0.tag == w_tag);
  assign w_hit1     = w_line1.valid && (w_line1.tag == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hit_way  = !w_hit0;
  assign w_hit_data = w_hit0 ? w_line0.data : w_line1.data;

  // Fill empty ways first (way0 before way1), otherwise evict the LRU way.
  assign w_miss_victim = !w_line0.valid ? 1'b0 : (!w_line1.valid ? 1'b1 : r_lru[w_index]);
  assign w_miss_line   = w_miss_victim ? w_line1 : w_line0;
  assign w_victim_tag  = r_lines[w_index][r_victim].tag;
  assign w_victim_data = r_lines[w_index][r_victim].data;

  assign w_mem_req  = (r_state == WRITEBACK) || (r_state == ALLOCATE);
  assign w_mem_wen  = (r_state == WRITEBACK);
  assign w_mem_addr = w_mem_wen ? {w_victim_tag[MEM_AW-INDEX_W-1:0], w_index}
                                : r_addr[MEM_AW+1:2];
  assign w_unused   = &{1'b0, reqAddress_CPU[1:0], w_victim_tag[TAG_W-1:MEM_AW-INDEX_W]};

  assign respDataOut_CPU = r_resp_data;
  assign respHit_CPU     = r_resp_hit;

  main_memory #(.LATENCY(MEM_LATENCY)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_mem_req),
    .i_wen   (w_mem_wen),
    .i_addr  (w_mem_addr),
    .i_wdata (w_victim_data),
    .o_rdata (w_mem_rdata),
    .o_ready (w_mem_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wen       <= 1'b0;
      r_lru       <= '0;
      r_victim    <= 1'b0;
      r_resp_data <= '0;
      r_resp_hit  <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_lines[s][0] <= '0;
        r_lines[s][1] <= '0;
      end
    end else begin
      r_resp_hit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (reqValid_CPU) begin
            r_addr  <= reqAddress_CPU[ADDR_W-1:2];
            r_wdata <= reqDataIn_CPU;
            r_wen   <= reqWen_CPU;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            if (r_wen) begin
              r_lines[w_index][w_hit_way].data  <= r_wdata;
              r_lines[w_index][w_hit_way].dirty <= 1'b1;
            end
            r_resp_data    <= r_wen ? r_wdata : w_hit_data;
            r_resp_hit     <= 1'b1;
            r_lru[w_index] <= ~w_hit_way;
            r_state        <= IDLE;
          end else begin
            r_victim <= w_miss_victim;
            r_state  <= (w_miss_line.valid && w_miss_line.dirty) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (w_mem_ready) begin
            r_state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (w_mem_ready) begin
            r_lines[w_index][r_victim] <= '{valid: 1'b1, dirty: 1'b0, tag: w_tag, data: w_mem_rdata};
            r_state <= COMPARE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_system.sv
// tb/tb_memory_system.sv - directed scoreboard bench for memory_system
module tb_memory_system;
  import memory_system_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic        reqWen;
  logic [31:0] respData;
  logic        respHit;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  memory_system #(.MEM_LATENCY(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .reqValid_CPU    (reqValid),
    .reqAddress_CPU  (reqAddr),
    .reqDataIn_CPU   (reqData),
    .reqWen_CPU      (reqWen),
    .respDataOut_CPU (respData),
    .respHit_CPU     (respHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] ex);
    n_checks++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, ex);
    end
  endtask

  // Latency counts negedges from the cycle the request is presented to the cycle respHit is seen.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] data, input logic wen,
                        input logic [31:0] exp_data, input int exp_lat, input string name);
    exp_t e;
    int   cyc;
    bit   seen;
    e.data = exp_data;
    e.lat  = exp_lat;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    reqValid = 1'b1;
    reqAddr  = addr;
    reqData  = data;
    reqWen   = wen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (respHit) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk({e.name, " data"}, respData, e.data);
        chk({e.name, " latency"}, 32'(cyc), 32'(e.lat));
      end
    end
    reqValid = 1'b0;
    chk({name, " response seen"}, 32'(seen), 32'd1);
    if (!seen) void'(sb.pop_front());
  endtask

  initial begin
    int cyc;
    rst      = 1'b0;
    reqValid = 1'b0;
    reqAddr  = '0;
    reqData  = '0;
    reqWen   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset respHit", 32'(respHit), 32'd0);
    chk("reset respData", respData, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle no response", 32'(respHit), 32'd0);
    end

    do_req(32'h00, 32'h002342ab, 1'b1, 32'h002342ab, 7,  "wr 00");
    do_req(32'h10, 32'h849292bb, 1'b1, 32'h849292bb, 7,  "wr 10");
    do_req(32'h20, 32'h19475820, 1'b1, 32'h19475820, 12, "wr 20 dirty evict");
    do_req(32'h18, 32'h55739084, 1'b1, 32'h55739084, 7,  "wr 18");
    do_req(32'h24, 32'h47390121, 1'b1, 32'h47390121, 7,  "wr 24");

    do_req(32'h00, 32'h0, 1'b0, 32'h002342ab, 12, "rd 00 dirty miss");
    do_req(32'h10, 32'h0, 1'b0, 32'h849292bb, 12, "rd 10 dirty miss");
    do_req(32'h00, 32'h0, 1'b0, 32'h002342ab, 2,  "rd 00 hit");
    do_req(32'h10, 32'h0, 1'b0, 32'h849292bb, 2,  "rd 10 hit");
    do_req(32'h20, 32'h0, 1'b0, 32'h19475820, 7,  "rd 20 clean victim");
    do_req(32'h30, 32'h0, 1'b0, 32'h00000000, 7,  "rd 30");

    do_req(32'h04, 32'h0, 1'b0, 32'h00000000, 7, "cold 04");
    do_req(32'h08, 32'h0, 1'b0, 32'h00000000, 7, "cold 08");
    do_req(32'h0C, 32'h0, 1'b0, 32'h00000000, 7, "cold 0C");
    do_req(32'h10, 32'h0, 1'b0, 32'h849292bb, 7, "rd 10 from memory");
    do_req(32'h00, 32'h0, 1'b0, 32'h002342ab, 7, "rd 00 from memory");

    // Held request on a hit: a pulse every second cycle, no memory activity.
    @(negedge clk);
    reqValid = 1'b1;
    reqAddr  = 32'h00;
    reqWen   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("held pulse pattern", 32'(respHit), 32'(i % 2 == 0));
      if (respHit) chk("held data", respData, 32'h002342ab);
      chk("held no mem traffic", 32'(dut.w_mem_req), 32'd0);
    end
    reqValid = 1'b0;

    do_req(32'h04, 32'haabbccdd, 1'b1, 32'haabbccdd, 2, "wr 04 hit");

    // Dirty miss on set 1; reset lands in the allocate phase after 0x24 is written back.
    sb.push_back('{data: 32'h0, lat: 0, name: "aborted rd 34"});
    @(negedge clk);
    reqValid = 1'b1;
    reqAddr  = 32'h34;
    reqWen   = 1'b0;
    for (cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      chk("no early response", 32'(respHit), 32'd0);
    end
    chk("in allocate before reset", 32'(dut.r_state), 32'(ALLOCATE));
    rst = 1'b0;
    #1;
    chk("reset drops respHit", 32'(respHit), 32'd0);
    chk("reset clears respData", respData, 32'd0);
    void'(sb.pop_front());
    reqValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_req(32'h04, 32'h0, 1'b0, 32'h00000000, 7, "rd 04 memory copy");
    do_req(32'h24, 32'h0, 1'b0, 32'h47390121, 7, "rd 24 written back");
    do_req(32'h04, 32'h0, 1'b0, 32'h00000000, 2, "rd 04 refilled hit");
    do_req(32'h34, 32'h0, 1'b0, 32'h00000000, 7, "rd 34 clean victim");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
